// File: rtl/mem_fill_unit.sv
// mem_fill_unit - cache line-fill engine.
//
// On a one-cycle miss pulse, issues a single burst read for the whole line,
// writes the returned beats into a line buffer, reports completion to the
// miss controller with a valid/ready handshake, and presents the assembled
// line plus the missed word to the array-update stage.
//
// Optional build macro: MEM_FILL_CWF_EN
//   defined   - critical word first: the burst starts at the missed word and
//               the memory wraps within the line.
//   undefined - burst starts at the line-aligned address.
//
// Ports:
//   clk, arst_n             clock, synchronous active-low reset
//   i_halt                  global stall, freezes all state
//   i_initiate_mem_req      miss-request pulse
//   i_miss_addr             missed word address, sampled with the pulse
//   i_mem_if_ready          miss controller accepts completion
//   o_mem_data_received     line complete, qualified by o_valid
//   o_mem_req_valid/addr    burst request to memory, i_mem_req_ready accepts
//   i_mem_rsp_valid/data    memory data beats, o_mem_rsp_ready accepts
//   o_line_addr             line-aligned address
//   o_line_data             assembled line, word k at [k*WORD_WIDTH +: WORD_WIDTH]
//   o_missed_word(_valid)   word at the missed offset and its capture flag
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | waiting for a miss pulse
// ST_REQ     | burst request presented to memory
// ST_COLLECT | accepting data beats into the line buffer
// ST_DONE    | completion reported, waiting for i_mem_if_ready
module mem_fill_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                 clk,
  input  logic                                 arst_n,
  input  logic                                 i_halt,
  input  logic                                 i_initiate_mem_req,
  input  logic [ADDR_WIDTH-1:0]                i_miss_addr,
  input  logic                                 i_mem_if_ready,
  output logic                                 o_mem_data_received,
  output logic                                 o_valid,
  output logic                                 o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]                o_mem_req_addr,
  input  logic                                 i_mem_req_ready,
  input  logic                                 i_mem_rsp_valid,
  input  logic [WORD_WIDTH-1:0]                i_mem_rsp_data,
  output logic                                 o_mem_rsp_ready,
  output logic [ADDR_WIDTH-1:0]                o_line_addr,
  output logic [WORDS_PER_LINE*WORD_WIDTH-1:0] o_line_data,
  output logic [WORD_WIDTH-1:0]                o_missed_word,
  output logic                                 o_missed_word_valid
);

  localparam int OFF = $clog2(WORDS_PER_LINE);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_COLLECT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [OFF:0] LAST_CNT = (OFF+1)'(WORDS_PER_LINE - 1);

  logic [1:0]            state;
  logic [OFF:0]          count;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WORD_WIDTH-1:0] line_buf [WORDS_PER_LINE];
  logic                  missed_valid_q;

  logic [OFF-1:0]        miss_off;
  logic [OFF-1:0]        start_off;
  logic [OFF-1:0]        slot;
  logic                  beat_acc;

  assign miss_off    = addr_q[OFF-1:0];
  assign o_line_addr = {addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};

`ifdef MEM_FILL_CWF_EN
  assign start_off      = miss_off;
  assign o_mem_req_addr = addr_q;
`else
  assign start_off      = '0;
  assign o_mem_req_addr = o_line_addr;
`endif

  // Slot index wraps naturally in OFF bits, giving modulo-line addressing.
  assign slot = start_off + count[OFF-1:0];

  // Handshake strobes drop during halt so no transfer can happen while frozen.
  assign o_mem_req_valid     = (state == ST_REQ)     && !i_halt;
  assign o_mem_rsp_ready     = (state == ST_COLLECT) && !i_halt;
  assign beat_acc            = o_mem_rsp_ready && i_mem_rsp_valid;

  assign o_mem_data_received = (state == ST_DONE);
  assign o_valid             = (state == ST_DONE);
  assign o_missed_word_valid = missed_valid_q;
  assign o_missed_word       = line_buf[miss_off];

  for (genvar k = 0; k < WORDS_PER_LINE; k++) begin : g_line
    assign o_line_data[k*WORD_WIDTH +: WORD_WIDTH] = line_buf[k];
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state          <= ST_IDLE;
      count          <= '0;
      addr_q         <= '0;
      missed_valid_q <= 1'b0;
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        line_buf[k] <= '0;
      end
    end else if (!i_halt) begin
      case (state)
        ST_IDLE: begin
          if (i_initiate_mem_req) begin
            addr_q         <= i_miss_addr;
            missed_valid_q <= 1'b0;
            count          <= '0;
            state          <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_mem_req_ready) begin
            state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (beat_acc) begin
            line_buf[slot] <= i_mem_rsp_data;
            count          <= count + 1'b1;
            if (slot == miss_off) begin
              missed_valid_q <= 1'b1;
            end
            if (count == LAST_CNT) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (i_mem_if_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fill_unit.sv
// tb_mem_fill_unit - directed self-checking bench for mem_fill_unit
// (N=4, 32-bit words/addresses). Works with MEM_FILL_CWF_EN defined or not.
module tb_mem_fill_unit;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         i_halt;
  logic         i_initiate_mem_req;
  logic [31:0]  i_miss_addr;
  logic         i_mem_if_ready;
  logic         o_mem_data_received;
  logic         o_valid;
  logic         o_mem_req_valid;
  logic [31:0]  o_mem_req_addr;
  logic         i_mem_req_ready;
  logic         i_mem_rsp_valid;
  logic [31:0]  i_mem_rsp_data;
  logic         o_mem_rsp_ready;
  logic [31:0]  o_line_addr;
  logic [127:0] o_line_data;
  logic [31:0]  o_missed_word;
  logic         o_missed_word_valid;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mem_fill_unit #(
    .ADDR_WIDTH(32), .WORD_WIDTH(32), .WORDS_PER_LINE(4)
  ) dut (
    .clk                 (clk),
    .arst_n              (arst_n),
    .i_halt              (i_halt),
    .i_initiate_mem_req  (i_initiate_mem_req),
    .i_miss_addr         (i_miss_addr),
    .i_mem_if_ready      (i_mem_if_ready),
    .o_mem_data_received (o_mem_data_received),
    .o_valid             (o_valid),
    .o_mem_req_valid     (o_mem_req_valid),
    .o_mem_req_addr      (o_mem_req_addr),
    .i_mem_req_ready     (i_mem_req_ready),
    .i_mem_rsp_valid     (i_mem_rsp_valid),
    .i_mem_rsp_data      (i_mem_rsp_data),
    .o_mem_rsp_ready     (o_mem_rsp_ready),
    .o_line_addr         (o_line_addr),
    .o_line_data         (o_line_data),
    .o_missed_word       (o_missed_word),
    .o_missed_word_valid (o_missed_word_valid)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_done"},  o_mem_data_received, 0);
    check_val({tag, "_valid"}, o_valid, 0);
    check_val({tag, "_reqv"},  o_mem_req_valid, 0);
    check_val({tag, "_rspr"},  o_mem_rsp_ready, 0);
    check_val({tag, "_laddr"}, o_line_addr, 0);
    check_val({tag, "_line"},  o_line_data, 0);
    check_val({tag, "_mword"}, o_missed_word, 0);
    check_val({tag, "_mwv"},   o_missed_word_valid, 0);
  endtask

  // Runs one fill; line holds the expected slot contents, the beats are sent
  // in wrap order starting at the burst start offset.
  task automatic run_fill(input string tag, input logic [31:0] addr, input logic [127:0] line,
                          input int req_wait, input int gap, input int halt_at, input int halt_len);
    logic [1:0]  off;
    logic [1:0]  start;
    logic [1:0]  s;
    logic [31:0] exp_req;
    logic        seen;
    off = addr[1:0];
`ifdef MEM_FILL_CWF_EN
    start   = off;
    exp_req = addr;
`else
    start   = 2'd0;
    exp_req = {addr[31:2], 2'b00};
`endif
    i_miss_addr        = addr;
    i_initiate_mem_req = 1'b1;
    tick();
    i_initiate_mem_req = 1'b0;
    check_val({tag, "_reqv"},  o_mem_req_valid, 1);
    check_val({tag, "_reqa"},  o_mem_req_addr, exp_req);
    check_val({tag, "_mwclr"}, o_missed_word_valid, 0);
    repeat (req_wait) tick();
    if (req_wait > 0) check_val({tag, "_reqheld"}, o_mem_req_valid, 1);
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    check_val({tag, "_rspr"},   o_mem_rsp_ready, 1);
    check_val({tag, "_reqoff"}, o_mem_req_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (gap) tick();
      s = start + 2'(i);
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data  = line[s*32 +: 32];
      tick();
      i_mem_rsp_valid = 1'b0;
      i_mem_rsp_data  = 32'h0BAD_0BAD;
      if (s == off) seen = 1'b1;
      check_val({tag, "_mwv"}, o_missed_word_valid, seen);
      if (i == halt_at) begin
        i_halt          = 1'b1;
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data  = 32'hDEAD_BEEF;
        #1;
        check_val({tag, "_haltrspr"}, o_mem_rsp_ready, 0);
        repeat (halt_len) tick();
        check_val({tag, "_haltnodone"}, o_mem_data_received, 0);
        i_halt          = 1'b0;
        i_mem_rsp_valid = 1'b0;
      end
      if (i < 3) check_val({tag, "_early"}, o_mem_data_received, 0);
    end
    check_val({tag, "_done"},    o_mem_data_received, 1);
    check_val({tag, "_valid"},   o_valid, 1);
    check_val({tag, "_rsprd"},   o_mem_rsp_ready, 0);
    check_val({tag, "_line"},    o_line_data, line);
    check_val({tag, "_laddr"},   o_line_addr, {addr[31:2], 2'b00});
    check_val({tag, "_mword"},   o_missed_word, line[off*32 +: 32]);
  endtask

  task automatic exit_done(input string tag);
    i_mem_if_ready = 1'b1;
    tick();
    i_mem_if_ready = 1'b0;
    check_val({tag, "_exit"},  o_mem_data_received, 0);
    check_val({tag, "_exitv"}, o_valid, 0);
  endtask

  localparam logic [127:0] LINE_A = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [127:0] LINE_B = 128'h000000B3_000000B2_000000B1_000000B0;
  localparam logic [127:0] LINE_C = 128'h0000C003_0000C002_0000C001_0000C000;
  localparam logic [127:0] LINE_D = 128'h0000D003_0000D002_0000D001_0000D000;
  localparam logic [127:0] LINE_E = 128'hE0000003_E0000002_E0000001_E0000000;

  initial begin
    arst_n = 1'b0; i_halt = 1'b0; i_initiate_mem_req = 1'b0; i_miss_addr = '0;
    i_mem_if_ready = 1'b0; i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0;
    i_mem_rsp_data = '0;
    tick(); tick();
    check_all_zero("reset");
    arst_n = 1'b1;
    tick();

    // stray beat in IDLE is not accepted
    i_mem_rsp_valid = 1'b1;
    i_mem_rsp_data  = 32'h1234_5678;
    #1;
    check_val("idle_rspr", o_mem_rsp_ready, 0);
    tick();
    i_mem_rsp_valid = 1'b0;
    check_val("idle_line", o_line_data, 0);

    // basic zero-wait fill: done exactly 6 cycles after the pulse
    run_fill("basic", 32'h0000_1006, LINE_A, 0, 0, -1, 0);
    exit_done("basic");

    // second pattern at same address (critical-word-first when enabled)
    run_fill("cwf", 32'h0000_1006, LINE_B, 0, 0, -1, 0);
    exit_done("cwf");

    // halt 3 cycles after beat 1
    run_fill("halt", 32'h0000_1101, LINE_C, 0, 0, 1, 3);

    // hold in DONE for 5 cycles, with an ignored pulse in the middle
    for (int c = 0; c < 5; c++) begin
      i_initiate_mem_req = (c == 2);
      i_miss_addr        = (c == 2) ? 32'h0000_5555 : 32'h0000_1101;
      tick();
      i_initiate_mem_req = 1'b0;
      check_val("hold_done",  o_mem_data_received, 1);
      check_val("hold_valid", o_valid, 1);
      check_val("hold_line",  o_line_data, LINE_C);
      check_val("hold_laddr", o_line_addr, 32'h0000_1100);
      check_val("hold_reqv",  o_mem_req_valid, 0);
    end
    exit_done("hold");
    check_val("hold_nopulse", o_mem_req_valid, 0);
    check_val("hold_laddr2",  o_line_addr, 32'h0000_1100);
    check_val("hold_mword",   o_missed_word, 32'h0000_C001);

    // reset after beat 2 abandons the fill
    i_miss_addr        = 32'h0000_3005;
    i_initiate_mem_req = 1'b1;
    tick();
    i_initiate_mem_req = 1'b0;
    i_mem_req_ready    = 1'b1;
    tick();
    i_mem_req_ready    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data  = 32'h3000_0000 + 32'(i);
      tick();
    end
    i_mem_rsp_valid = 1'b0;
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    check_all_zero("midrst");
    tick(); tick();
    check_val("midrst_nodone", o_mem_data_received, 0);
    check_val("midrst_noreq",  o_mem_req_valid, 0);
    run_fill("fresh", 32'h0000_2000, LINE_D, 0, 0, -1, 0);
    exit_done("fresh");

    // request backpressure and gaps between beats
    run_fill("bp", 32'h0000_400B, LINE_E, 4, 2, -1, 0);
    exit_done("bp");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
